// File: rtl/serial_defs.sv
// serial_defs: state encodings and line levels shared by the serial transmitter and receiver
package serial_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam logic IDLE_LVL = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/baud_tick.sv
// baud_tick: free-running bit-period counter, tick on the last clock of each bit
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/serial_tx.sv
// serial_tx: valid/ready parallel-to-serial frame transmitter (start, data LSB-first, stop)
module serial_tx
  import serial_defs::*;
#(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state;
  logic [DATA_W-1:0] sh;
  logic [IW-1:0] idx;
  logic bit_done;
  assign tx_ready = state == IDLE;
  assign busy = !tx_ready;
  // Held clear while idle; every other transition lands on a tick, where the counter wraps to 0.
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .tick(bit_done)
  );
  // tx is loaded with the next bit as it is shifted out, so the line always comes straight from a flop.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      tx <= IDLE_LVL;
      sh <= '0;
      idx <= '0;
    end else
      case (state)
        IDLE: if (tx_valid) begin
          sh <= tx_data;
          tx <= START_LVL;
          state <= START;
        end
        START: if (bit_done) begin
          tx <= sh[0];
          sh <= sh >> 1;
          idx <= '0;
          state <= DATA;
        end
        DATA: if (bit_done) begin
          if (idx == IW'(DATA_W - 1)) begin
            tx <= STOP_LVL;
            state <= STOP;
          end else begin
            tx <= sh[0];
            sh <= sh >> 1;
            idx <= idx + IW'(1);
          end
        end
        STOP: if (bit_done) begin
          tx <= IDLE_LVL;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed and random frames checked against a per-cycle line model
module tb_serial_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, tx, busy;
  logic [4:0] tx_data2 = '0;
  logic tx_valid2 = 1'b0;
  logic tx_ready2, tx2, busy2;
  int errors = 0;
  int checks = 0;
  logic [7:0] d;

  serial_tx dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );
  serial_tx #(.DATA_W(5), .CLKS_PER_BIT(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2)
  );

  // Line level k cycles after the handshake edge: bit slot p = k / c.
  function automatic logic exp_tx(logic [31:0] w_d, int w, int c, int k);
    int p;
    p = k / c;
    return p == 0 ? 1'b0 : p <= w ? w_d[p-1] : 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_check(input logic [7:0] fd, input bit scramble);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("frame_tx[%0d]", k), tx, exp_tx(fd, 8, 4, k));
      chk("frame_busy", busy, 1);
      chk("frame_ready", tx_ready, 0);
      if (scramble) tx_data = 8'($urandom);
      @(negedge clk);
    end
    chk("idle_tx", tx, 1);
    chk("idle_ready", tx_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic send(input logic [7:0] sd);
    @(negedge clk);
    tx_data = sd;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    frame_check(sd, 1'b1);
  endtask

  task automatic send2(input logic [4:0] sd);
    @(negedge clk);
    tx_data2 = sd;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("w5_tx[%0d]", k), tx2, exp_tx(sd, 5, 1, k));
      chk("w5_busy", busy2, 1);
      @(negedge clk);
    end
    chk("w5_idle_tx", tx2, 1);
    chk("w5_idle_ready", tx_ready2, 1);
  endtask

  initial begin
    tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
    end
    tx_valid = 1'b0;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_tx", tx, 1);
      chk("post_rst_ready", tx_ready, 1);
    end
    send(8'hA5);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    // Back-to-back with tx_valid held: second word must wait for the idle cycle.
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    frame_check(8'h00, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    frame_check(8'hFF, 1'b1);
    // tx_valid raised mid-frame with churning data; 0x3C is presented once ready.
    d = 8'($urandom);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k < 40) begin
        chk($sformatf("hold_tx[%0d]", k), tx, exp_tx(d, 8, 4, k));
        chk("hold_ready", tx_ready, 0);
      end else begin
        chk("hold_idle_tx", tx, 1);
        chk("hold_idle_ready", tx_ready, 1);
      end
      if (k >= 10) begin
        tx_valid = 1'b1;
        tx_data = k == 40 ? 8'h3C : 8'($urandom);
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    frame_check(8'h3C, 1'b1);
    // Asynchronous abort during data bit 3 (a 0 bit of 0xF0).
    @(negedge clk);
    tx_data = 8'hF0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("abort_tx[%0d]", k), tx, exp_tx(8'hF0, 8, 4, k));
      @(negedge clk);
    end
    chk("abort_bit3", tx, 0);
    rst = 1'b0;
    #1;
    chk("abort_async_tx", tx, 1);
    chk("abort_async_ready", tx_ready, 1);
    chk("abort_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_release_tx", tx, 1);
      chk("abort_release_ready", tx_ready, 1);
    end
    send(8'h81);
    send2(5'h13);
    for (int i = 0; i < 3; i++) send2(5'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial frame transmitter. Accepts a DATA_W-bit word on a valid/ready handshake and shifts it out on a single registered line as start bit, data LSB-first, then stop bit. Each bit is held for CLKS_PER_BIT clocks. It is the driving end of the single-bit serial line that the team's flip-flop/receiver side samples.

Parameters:
DATA_W, 8, payload bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each bit is held on tx (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_valid  input  1  upstream has a word
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, registered, idle high
busy  output  1  frame in progress (START/DATA/STOP)

Behaviour:
- Reset (rst=0, async): state=IDLE, tx=1, tx_ready=1, busy=0, bit counter=0, shift register=0. Deassertion is synchronous-safe; first handshake possible on first edge with rst=1.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, tx_ready=1, busy=0. On an edge with tx_valid=1: latch tx_data into the shift register, go to START. tx_data ignored when tx_valid=0.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift_reg[0], each bit held CLKS_PER_BIT cycles, shift right after each bit; after DATA_W bits go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx_ready=1 only in IDLE; busy is its complement. tx_ready is a combinational decode of registered state (no dependence on tx_valid).
- Latency: handshake on edge N -> tx=0 visible after edge N; start bit occupies cycles N..N+CLKS_PER_BIT-1.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles. Minimum one IDLE cycle (tx=1) between frames, so back-to-back period = (DATA_W+2)*CLKS_PER_BIT+1.
- tx_valid high while busy: no effect; word not consumed, upstream must hold it until tx_ready.
- tx_data changes mid-frame: no effect on frame in progress.
- Baud counter: counts 0..CLKS_PER_BIT-1, width max(1,$clog2(CLKS_PER_BIT)); bit_done when count==CLKS_PER_BIT-1; count cleared on every state transition. CLKS_PER_BIT=1: bit_done every cycle.
- Bit index: width max(1,$clog2(DATA_W)), cleared on entry to DATA.
- Reset mid-frame: immediate abort, tx=1 asynchronously, frame discarded, no partial completion after release.
- No glitches on tx: driven directly from a flop.

Decomposition:
- Shared package/include serial_defs: state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), line levels IDLE_LVL=1, START_LVL=0, STOP_LVL=1. The future receiver uses the same definitions.
- One sub-module: baud_tick (params CLKS_PER_BIT; ports clk, rst, clr, tick). It produces bit_done and is reused by the receiver.

Test Plan:
- Reset: hold rst=0 20 cycles while driving tx_valid=1 -> tx=1, tx_ready=1, busy=0 throughout, nothing sent after release until a handshake.
- Single frame 0xA5 (defaults): pulse tx_valid 1 cycle -> tx sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1. Total 40 cycles busy, then tx_ready=1.
- Back-to-back 0x00 then 0xFF with tx_valid held -> second start bit begins exactly 41 cycles after first handshake. Data bits all 0 then all 1.
- Valid during busy: assert tx_valid with 0x3C mid-frame, change tx_data each cycle -> current frame unchanged, 0x3C-holder word sent only after tx_ready.
- Reset mid-DATA: rst=0 at bit 3 -> tx=1 same cycle (async), state IDLE. After release the next frame 0x81 is sent cleanly.
- Parameter sweep: CLKS_PER_BIT=1, DATA_W=5, send 5'h13 -> 7-cycle frame 0,1,1,0,0,1,1.
